mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one physical memory port between the fetch stage (imem) and the MEM stage (dmem) of the RV32I pipeline.
- Accepts one request at a time, drives registered address/mask/data onto the memory port, and routes the response back to the owner.
- dmem has priority; a starvation counter guarantees imem forward progress.
- Sits between the pipeline stages and the memory model/cache.

Parameters:
STARVE_MAX, 4, consecutive dmem grants while imem waits before imem is forced ahead (legal range 1..15).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
imem_addr  in  32  fetch address (word aligned)
imem_rmask  in  4  fetch read mask; nonzero = imem request pending
imem_rdata  out  32  fetch data, valid when imem_resp=1
imem_resp  out  1  one-cycle fetch completion
dmem_addr  in  32  MEM-stage byte address
dmem_rmask  in  4  load mask; nonzero = load pending
dmem_wmask  in  4  store mask; nonzero = store pending
dmem_wdata  in  32  store data, lane-aligned
dmem_rdata  out  32  load data, valid when dmem_resp=1
dmem_resp  out  1  one-cycle load/store completion
mem_addr  out  32  port address, bits[1:0] forced to 0
mem_rmask  out  4  port read mask
mem_wmask  out  4  port write mask
mem_wdata  out  32  port write data
mem_rdata  in  32  port read data
mem_resp  in  1  port completion, 1 cycle per request
proto_err  out  1  sticky: mem_resp seen in IDLE, or dmem rmask and wmask both nonzero

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_addr, mem_rmask, mem_wmask, mem_wdata, starve_cnt and proto_err all 0. imem_resp and dmem_resp are 0 for the whole time rst is low.
- Request protocol:
  - A requester holds its request stable until its resp.
  - In the cycle after resp it drops the request or presents a new one.
  - In IDLE, any nonzero mask is a new request.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE, grant selection:
  - dmem pending and (imem idle or starve_cnt < STARVE_MAX) -> SERVE_D.
  - Else imem pending -> SERVE_I.
  - Else stay in IDLE.
- Grant, cycle N: the winner's addr ({addr[31:2],2'b00}), masks and wdata are registered onto mem_*, visible at N+1. For an imem grant, mem_wmask=0 and mem_wdata=0.
- SERVE_x: mem_* held constant until mem_resp=1.
  - In that cycle x_resp=1 combinationally and x_rdata=mem_rdata.
  - mem_* clear to 0 on the next edge; state -> IDLE.
  - Minimum turnaround: request at N, port active N+1, earliest resp N+1, next grant N+2.
- Non-owner resp is always 0. imem_rdata and dmem_rdata are 0 when their resp is 0.
- starve_cnt (saturating at STARVE_MAX):
  - +1 on each dmem grant while imem is pending.
  - Reset to 0 on each imem grant, or when imem is not pending at a grant decision.
- proto_err:
  - Set on mem_resp=1 in IDLE; that resp is ignored and no requester resp is raised.
  - Set on a dmem request with both masks nonzero; that request is served as a store (rmask dropped).
  - Cleared only by reset.
- Simultaneous imem and dmem requests in IDLE with starve_cnt < STARVE_MAX: dmem wins.
- Requests arriving while SERVE_x is active are not sampled until the return to IDLE.
- Reset mid-transaction: state abandoned immediately and mem_* zeroed. A late mem_resp after reset is released sets proto_err.

Test Plan:
1. Reset, then imem_rmask=F, addr 0x1000_0006, mem_resp at 3rd cycle -> mem_addr 0x1000_0004 and mem_rmask F from N+1; imem_resp=1 with imem_rdata=mem_rdata exactly in the resp cycle; mem_* = 0 afterward.
2. dmem store wmask=4'b0100, wdata 0x00AB_0000, addr 0x2002 -> mem_wmask 0100, mem_wdata 0x00AB_0000, mem_rmask 0; dmem_resp one cycle; imem_resp stays 0.
3. imem and dmem load asserted the same cycle -> dmem served first; imem granted in the cycle after dmem_resp.
4. imem held pending, dmem reissuing back-to-back, STARVE_MAX=4 -> exactly 4 dmem grants, then an imem grant, then dmem resumes.
5. mem_resp pulsed in IDLE -> proto_err=1 and stays 1; no imem_resp or dmem_resp; a subsequent normal transaction still completes.
6. rst driven low asynchronously mid-SERVE_D -> mem_* = 0 and resps 0 without a clock edge; after release, state IDLE and a new imem request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between imem (fetch) and dmem (MEM stage)
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        proto_err
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  starve_cnt;
    logic        imem_pend;
    logic        dmem_pend;
    logic        grant_d;
    logic        grant_i;
    logic        unused_addr_bits;

    assign imem_pend = |imem_rmask;
    assign dmem_pend = (|dmem_rmask) || (|dmem_wmask);

    // dmem wins unless imem has already been passed over STARVE_MAX times
    assign grant_d = (state == IDLE) && dmem_pend && (!imem_pend || (starve_cnt < STARVE_LIM));
    assign grant_i = (state == IDLE) && !grant_d && imem_pend;

    assign unused_addr_bits = ^{imem_addr[1:0], dmem_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = SERVE_D;
                end else if (grant_i) begin
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign imem_resp  = (state == SERVE_I) && mem_resp;
    assign dmem_resp  = (state == SERVE_D) && mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
    assign dmem_rdata = dmem_resp ? mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr   <= 32'h0;
            mem_rmask  <= 4'h0;
            mem_wmask  <= 4'h0;
            mem_wdata  <= 32'h0;
            starve_cnt <= 4'h0;
            proto_err  <= 1'b0;
        end else begin
            if (grant_d) begin
                mem_addr  <= {dmem_addr[31:2], 2'b00};
                // a load+store request is served as a store only
                mem_rmask <= (|dmem_wmask) ? 4'h0 : dmem_rmask;
                mem_wmask <= dmem_wmask;
                mem_wdata <= dmem_wdata;
            end else if (grant_i) begin
                mem_addr  <= {imem_addr[31:2], 2'b00};
                mem_rmask <= imem_rmask;
                mem_wmask <= 4'h0;
                mem_wdata <= 32'h0;
            end else if ((state != IDLE) && mem_resp) begin
                mem_addr  <= 32'h0;
                mem_rmask <= 4'h0;
                mem_wmask <= 4'h0;
                mem_wdata <= 32'h0;
            end

            if (state == IDLE) begin
                if (!imem_pend || grant_i) begin
                    starve_cnt <= 4'h0;
                end else if (grant_d && (starve_cnt < STARVE_LIM)) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end

            if ((state == IDLE) && mem_resp) begin
                proto_err <= 1'b1;
            end
            if (grant_d && (|dmem_rmask) && (|dmem_wmask)) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter against a transaction model
module tb_mem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        proto_err;

    mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Transaction model: owner 0 = port free, 1 = imem, 2 = dmem
    int          m_owner;
    int          m_starve;
    logic [31:0] m_addr;
    logic [3:0]  m_rmask;
    logic [3:0]  m_wmask;
    logic [31:0] m_wdata;
    logic        m_err;
    bit          saw_i;
    bit          saw_d;
    int          cyc;
    int          resp_who[$];
    int          resp_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_starve = 0;
        m_addr   = 0;
        m_rmask  = 0;
        m_wmask  = 0;
        m_wdata  = 0;
        m_err    = 0;
    endtask

    task automatic drive_idle();
        imem_rmask = 0;
        imem_addr  = 0;
        dmem_rmask = 0;
        dmem_wmask = 0;
        dmem_addr  = 0;
        dmem_wdata = 0;
    endtask

    task automatic new_dmem_load();
        dmem_addr  = $urandom;
        dmem_rmask = 4'($urandom_range(1, 15));
        dmem_wmask = 0;
        dmem_wdata = $urandom;
    endtask

    task automatic new_dmem_store();
        dmem_addr  = $urandom;
        dmem_rmask = 0;
        dmem_wmask = 4'($urandom_range(1, 15));
        dmem_wdata = $urandom;
    endtask

    // Called at posedge+1 with this cycle's inputs applied; returns at the next posedge+1
    task automatic tick();
        logic ip, dp, ei, ed;
        #2;
        ei = (m_owner == 1) && mem_resp;
        ed = (m_owner == 2) && mem_resp;
        check_eq("imem_resp", imem_resp, ei);
        check_eq("dmem_resp", dmem_resp, ed);
        check_eq("imem_rdata", imem_rdata, ei ? mem_rdata : 32'h0);
        check_eq("dmem_rdata", dmem_rdata, ed ? mem_rdata : 32'h0);
        check_eq("mem_addr", mem_addr, m_addr);
        check_eq("mem_rmask", mem_rmask, m_rmask);
        check_eq("mem_wmask", mem_wmask, m_wmask);
        check_eq("mem_wdata", mem_wdata, m_wdata);
        check_eq("proto_err", proto_err, m_err);
        if (imem_resp) begin resp_who.push_back(1); resp_cyc.push_back(cyc); end
        if (dmem_resp) begin resp_who.push_back(2); resp_cyc.push_back(cyc); end
        saw_i = ei;
        saw_d = ed;
        if (m_owner != 0) begin
            if (mem_resp) begin
                m_owner = 0; m_addr = 0; m_rmask = 0; m_wmask = 0; m_wdata = 0;
            end
        end else begin
            if (mem_resp) m_err = 1;
            ip = |imem_rmask;
            dp = (|dmem_rmask) || (|dmem_wmask);
            if (dp && (!ip || m_starve < SMAX)) begin
                m_owner = 2;
                m_addr  = dmem_addr & ~32'h3;
                m_wmask = dmem_wmask;
                m_rmask = (dmem_wmask != 0) ? 4'h0 : dmem_rmask;
                m_wdata = dmem_wdata;
                if (dmem_rmask != 0 && dmem_wmask != 0) m_err = 1;
                m_starve = ip ? ((m_starve < SMAX) ? m_starve + 1 : m_starve) : 0;
            end else if (ip) begin
                m_owner = 1;
                m_addr  = imem_addr & ~32'h3;
                m_rmask = imem_rmask;
                m_wmask = 0;
                m_wdata = 0;
                m_starve = 0;
            end else begin
                m_starve = 0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Memory answers at once; requesters drop after resp, dmem optionally reissues a new load
    task automatic auto_run(input int n, input bit d_reissue);
        for (int k = 0; k < n; k++) begin
            mem_resp  = (m_owner != 0);
            mem_rdata = $urandom;
            tick();
            if (saw_i) imem_rmask = 0;
            if (saw_d) begin
                if (d_reissue) new_dmem_load();
                else begin dmem_rmask = 0; dmem_wmask = 0; end
            end
        end
        mem_resp = 0;
    endtask

    int exp4[6] = '{2, 2, 2, 2, 1, 2};

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 0;
        drive_idle();
        mem_resp  = 1;
        mem_rdata = 32'h1234_5678;
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_rmask", mem_rmask, 4'h0);
        check_eq("rst_mem_wmask", mem_wmask, 4'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_proto_err", proto_err, 1'b0);
        check_eq("rst_imem_resp", imem_resp, 1'b0);
        check_eq("rst_dmem_resp", dmem_resp, 1'b0);
        mem_resp = 0;
        rst = 1;
        tick();

        // imem fetch with port answering on the third cycle
        imem_rmask = 4'hF;
        imem_addr  = 32'h1000_0006;
        tick();
        check_eq("t1_addr", mem_addr, 32'h1000_0004);
        check_eq("t1_rmask", mem_rmask, 4'hF);
        tick();
        mem_resp  = 1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        check_eq("t1_saw_resp", saw_i, 1'b1);
        check_eq("t1_clear", mem_rmask, 4'h0);
        imem_rmask = 0;
        mem_resp   = 0;
        tick();

        // dmem byte store
        dmem_addr  = 32'h0000_2002;
        dmem_wmask = 4'b0100;
        dmem_wdata = 32'h00AB_0000;
        tick();
        check_eq("t2_addr", mem_addr, 32'h0000_2000);
        check_eq("t2_wmask", mem_wmask, 4'b0100);
        check_eq("t2_wdata", mem_wdata, 32'h00AB_0000);
        check_eq("t2_rmask", mem_rmask, 4'h0);
        mem_resp = 1;
        tick();
        dmem_wmask = 0;
        mem_resp   = 0;
        tick();

        // simultaneous requests: dmem first, imem granted right after
        resp_who.delete();
        resp_cyc.delete();
        imem_rmask = 4'hF;
        imem_addr  = 32'h0000_0100;
        new_dmem_load();
        auto_run(8, 0);
        check_eq("t3_count", resp_who.size(), 2);
        check_eq("t3_first", (resp_who.size() > 0) ? resp_who[0] : -1, 2);
        check_eq("t3_second", (resp_who.size() > 1) ? resp_who[1] : -1, 1);
        check_eq("t3_gap", (resp_cyc.size() > 1) ? resp_cyc[1] - resp_cyc[0] : -1, 2);

        // starvation bound: SMAX dmem grants, then imem, then dmem again
        resp_who.delete();
        resp_cyc.delete();
        imem_rmask = 4'hF;
        imem_addr  = 32'h0000_0200;
        new_dmem_load();
        auto_run(14, 1);
        dmem_rmask = 0;
        dmem_wmask = 0;
        auto_run(4, 0);
        for (int i = 0; i < 6; i++)
            check_eq($sformatf("t4_seq%0d", i), (i < resp_who.size()) ? resp_who[i] : -1, exp4[i]);

        // stray port response while idle
        drive_idle();
        auto_run(3, 0);
        mem_resp = 1;
        tick();
        mem_resp = 0;
        tick();
        check_eq("t5_err", proto_err, 1'b1);
        resp_who.delete();
        imem_rmask = 4'hF;
        imem_addr  = 32'h0000_0300;
        auto_run(4, 0);
        check_eq("t5_after", (resp_who.size() > 0) ? resp_who[resp_who.size()-1] : -1, 1);
        check_eq("t5_sticky", proto_err, 1'b1);

        // asynchronous reset in the middle of a dmem store
        dmem_addr  = 32'h0000_4000;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("t6_pre_wmask", mem_wmask, 4'hF);
        mem_resp = 1;
        #1;
        rst = 0;
        #1;
        check_eq("t6_addr", mem_addr, 32'h0);
        check_eq("t6_wmask", mem_wmask, 4'h0);
        check_eq("t6_wdata", mem_wdata, 32'h0);
        check_eq("t6_dresp", dmem_resp, 1'b0);
        check_eq("t6_iresp", imem_resp, 1'b0);
        check_eq("t6_err", proto_err, 1'b0);
        model_reset();
        drive_idle();
        @(posedge clk);
        #1;
        rst = 1;
        tick();
        mem_resp = 0;
        resp_who.delete();
        imem_rmask = 4'hF;
        imem_addr  = 32'h0000_0400;
        auto_run(4, 0);
        check_eq("t6_igrant", (resp_who.size() > 0) ? resp_who[0] : -1, 1);

        // randomized traffic against the model
        drive_idle();
        for (int c = 0; c < 1500; c++) begin
            mem_rdata = $urandom;
            mem_resp  = (m_owner != 0) && ($urandom_range(0, 1) == 1);
            tick();
            if (saw_i) imem_rmask = 0;
            if (imem_rmask == 0 && !saw_i && $urandom_range(0, 2) == 0) begin
                imem_rmask = 4'hF;
                imem_addr  = $urandom;
            end else if (saw_i && $urandom_range(0, 1) == 1) begin
                imem_rmask = 4'hF;
                imem_addr  = $urandom;
            end
            if (saw_d) begin dmem_rmask = 0; dmem_wmask = 0; end
            if ((dmem_rmask == 0 && dmem_wmask == 0) && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 7))
                    0: begin new_dmem_store(); dmem_rmask = 4'($urandom_range(1, 15)); end
                    1, 2, 3: new_dmem_load();
                    default: new_dmem_store();
                endcase
            end
        end
        drive_idle();
        auto_run(3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
